// File: rtl/fifo_rd_cntrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_cntrl_pkg
// Shared asynchronous-FIFO package, used by both the read-side and the
// write-side controllers.
//   - DATA_WIDTH_DEF / ADDR_SIZE_DEF : default data width and address width
//   - ptr_wide_t                     : 32-bit container for the pointer helpers
//   - bin_to_gray / gray_to_bin      : pointer code conversions
// The helpers work on a 32-bit container, so one pair of functions serves
// every pointer width. Callers zero-extend their operand and then truncate
// the result. Leading zeros do not change either conversion.
// -----------------------------------------------------------------------------
package fifo_rd_cntrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_SIZE_DEF  = 3;
    localparam int PTR_W_MAX      = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_wide_t;

    function automatic ptr_wide_t bin_to_gray(input ptr_wide_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down. Doubling the shift distance covers
    // 32 bits in five steps.
    function automatic ptr_wide_t gray_to_bin(input ptr_wide_t gray);
        ptr_wide_t bin;
        bin = gray;
        for (int s = 1; s < PTR_W_MAX; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter, parameterised by width.
//   gray_i : Gray-coded input  [WIDTH-1:0]
//   bin_o  : binary equivalent [WIDTH-1:0]
// -----------------------------------------------------------------------------
module gray2bin
    import fifo_rd_cntrl_pkg::*;
#(
    parameter int WIDTH = ADDR_SIZE_DEF + 1
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    assign bin_o = WIDTH'(gray_to_bin(ptr_wide_t'(gray_i)));

endmodule

// File: rtl/fifo_rd_cntrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_cntrl
// Read-side controller of an asynchronous FIFO, clocked by rclk only.
// It drives the read address into an external memory and registers the word
// it reads into a valid/ready output stage.
//   rclk      : read-domain clock
//   RST       : asynchronous active-high reset; release must be synchronous
//               to rclk at system level
//   rq2_wptr  : Gray write pointer, already synchronised into rclk
//   mem_rdata : combinational memory read data at raddr
//   rd_ready  : consumer accepts rd_data this cycle
//   raddr     : memory read address (low bits of the binary read pointer)
//   rptr      : registered Gray read pointer, for the write domain
//   rempty    : registered storage-empty flag
//   rd_data   : registered output word
//   rd_valid  : rd_data holds an unconsumed word
//   rd_count  : registered storage occupancy, excluding the word in rd_data
// -----------------------------------------------------------------------------
module fifo_rd_cntrl
    import fifo_rd_cntrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF
) (
    input  logic                  rclk,
    input  logic                  RST,
    input  logic [ADDR_SIZE:0]    rq2_wptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  rd_ready,
    output logic [ADDR_SIZE-1:0]  raddr,
    output logic [ADDR_SIZE:0]    rptr,
    output logic                  rempty,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_SIZE:0]    rd_count
);

    localparam int PTR_W = ADDR_SIZE + 1;

    logic [PTR_W-1:0]      rbin_q, rbin_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W-1:0]      rd_count_q, rd_count_d;
    logic                  rempty_q, rempty_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [PTR_W-1:0]      wbin;
    logic                  pop;

    gray2bin #(
        .WIDTH (PTR_W)
    ) u_wptr_g2b (
        .gray_i (rq2_wptr),
        .bin_o  (wbin)
    );

    // Pop whenever storage holds a word and the output stage is free or is
    // being drained this cycle. This sustains one word per cycle under
    // continuous rd_ready.
    assign pop = !rempty_q && (!rd_valid_q || rd_ready);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        rbin_d     = rbin_q + PTR_W'(pop);
        rptr_d     = PTR_W'(bin_to_gray(ptr_wide_t'(rbin_d)));
        rempty_d   = (rptr_d == rq2_wptr);
        // Modulo subtraction keeps the count correct across pointer wrap.
        // It reads DEPTH when the write pointer is a full lap ahead.
        rd_count_d = wbin - rbin_d;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (pop) begin
            rd_data_d  = mem_rdata;
            rd_valid_d = 1'b1;
        end else if (rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge rclk or posedge RST) begin
        if (RST) begin
            rbin_q     <= '0;
            rptr_q     <= '0;
            rd_count_q <= '0;
            rempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rptr_q     <= rptr_d;
            rd_count_q <= rd_count_d;
            rempty_q   <= rempty_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign raddr    = rbin_q[ADDR_SIZE-1:0];
    assign rptr     = rptr_q;
    assign rempty   = rempty_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_rd_cntrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_cntrl
// Self-checking bench for fifo_rd_cntrl (DATA_WIDTH=8, ADDR_SIZE=3).
// The reference model tracks the FIFO as counts:
//   - pops so far, modulo 16
//   - writes so far, modulo 16
//   - the word currently held in the output stage
// Empty and occupancy follow from the difference of the two counts.
// -----------------------------------------------------------------------------
module tb_fifo_rd_cntrl;

    localparam int DEPTH = 8;
    localparam int LAP   = 16;

    logic       rclk = 1'b0;
    logic       RST;
    logic [3:0] rq2_wptr;
    logic [7:0] mem_rdata;
    logic       rd_ready;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] rd_count;

    logic [7:0] tb_mem [DEPTH];
    int         w_cnt;

    // Reference model state
    int         m_rd;
    bit         m_empty;
    bit         m_valid;
    logic [7:0] m_data;
    int         m_count;

    int         n_checks;
    int         n_fail;

    function automatic logic [3:0] gray4(input int b);
        int v;
        v = b % LAP;
        return 4'(v ^ (v >> 1));
    endfunction

    assign rq2_wptr  = gray4(w_cnt);
    assign mem_rdata = tb_mem[raddr];

    always #5 rclk = ~rclk;

    fifo_rd_cntrl #(
        .DATA_WIDTH (8),
        .ADDR_SIZE  (3)
    ) dut (
        .rclk      (rclk),
        .RST       (RST),
        .rq2_wptr  (rq2_wptr),
        .mem_rdata (mem_rdata),
        .rd_ready  (rd_ready),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_count  (rd_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd    = 0;
        m_empty = 1'b1;
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_count = 0;
    endtask

    // One rclk edge of the FIFO, described by counts rather than pointers.
    task automatic model_edge();
        bit pop;
        pop = !m_empty && (!m_valid || rd_ready);
        if (pop) begin
            m_data  = tb_mem[m_rd % DEPTH];
            m_valid = 1'b1;
            m_rd    = (m_rd + 1) % LAP;
        end else if (rd_ready) begin
            m_valid = 1'b0;
        end
        m_count = (w_cnt - m_rd + LAP) % LAP;
        m_empty = (m_count == 0);
    endtask

    task automatic check_outputs();
        check("raddr",    32'(raddr),    32'(m_rd % DEPTH));
        check("rptr",     32'(rptr),     32'(gray4(m_rd)));
        check("rempty",   32'(rempty),   32'(m_empty));
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("rd_data",  32'(rd_data),  32'(m_data));
        check("rd_count", 32'(rd_count), 32'(m_count));
    endtask

    // Called just after a falling edge. Inputs stay stable until the next
    // rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge rclk);
        model_edge();
        #1;
        check_outputs();
        @(negedge rclk);
    endtask

    // Asynchronous reset between clock edges. Outputs must reset with no
    // edge. Release happens on a falling edge.
    task automatic do_reset(input int new_w);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_outputs();
        w_cnt = new_w;
        @(negedge rclk);
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rd_ready = 1'b0;
        w_cnt    = 6;                      // rq2_wptr = 4'b0101 during reset
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'($urandom);
        RST = 1'b1;
        model_reset();

        // Reset: outputs forced immediately, before any clock edge.
        #1;
        check("rst_rempty", 32'(rempty),   32'd1);
        check("rst_valid",  32'(rd_valid), 32'd0);
        check("rst_raddr",  32'(raddr),    32'd0);
        check("rst_rptr",   32'(rptr),     32'd0);
        check("rst_count",  32'(rd_count), 32'd0);
        w_cnt = 0;
        @(negedge rclk);
        RST = 1'b0;

        // Single word, held under backpressure until accepted.
        tb_mem[0] = 8'hA5;
        tick();
        w_cnt = 1;
        tick();
        check("sw_empty_fall", 32'(rempty), 32'd0);
        tick();
        check("sw_valid", 32'(rd_valid), 32'd1);
        check("sw_data",  32'(rd_data),  32'hA5);
        check("sw_raddr", 32'(raddr),    32'd1);
        check("sw_empty", 32'(rempty),   32'd1);
        repeat (3) tick();
        check("sw_hold", 32'(rd_valid), 32'd1);
        rd_ready = 1'b1;
        tick();
        check("sw_taken", 32'(rd_valid), 32'd0);

        // Backpressure: three words, only one pop, word stays stable.
        rd_ready = 1'b0;
        do_reset(3);
        repeat (12) tick();
        check("bp_raddr", 32'(raddr),    32'd1);
        check("bp_count", 32'(rd_count), 32'd2);
        check("bp_data",  32'(rd_data),  32'(tb_mem[0]));

        // Full: write pointer one lap ahead, then drain eight words back to back.
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'(8'h10 + i);
        rd_ready = 1'b1;
        do_reset(8);
        tick();
        check("full_count", 32'(rd_count), 32'd8);
        check("full_empty", 32'(rempty),   32'd0);
        repeat (8) tick();
        check("drain_rptr",  32'(rptr),     32'b1100);
        check("drain_empty", 32'(rempty),   32'd1);
        check("drain_count", 32'(rd_count), 32'd0);
        check("drain_last",  32'(rd_data),  32'h17);

        // Wrap: advance the read pointer to 15, then read across the wrap.
        w_cnt = 15;
        repeat (9) tick();
        check("pre_wrap_rptr", 32'(rptr), 32'b1000);
        w_cnt = 1;
        tick();
        check("wrap_count", 32'(rd_count), 32'd2);
        tick();
        check("wrap_raddr", 32'(raddr),  32'd0);
        check("wrap_rptr",  32'(rptr),   32'b0000);
        check("wrap_empty", 32'(rempty), 32'd0);
        tick();
        check("wrap_done", 32'(rempty), 32'd1);

        // Mid-stream reset while a word is held and four remain in storage.
        rd_ready = 1'b0;
        do_reset(5);
        tick();
        tick();
        check("mid_valid", 32'(rd_valid), 32'd1);
        check("mid_count", 32'(rd_count), 32'd4);
        do_reset(0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_data",  32'(rd_data),  32'd0);
        repeat (3) tick();
        check("mid_after_empty", 32'(rempty), 32'd1);

        // Random traffic: variable ready duty and write rate, never overfilling.
        do_reset(0);
        for (int cyc = 0; cyc < 800; cyc++) begin
            int room;
            rd_ready = ($urandom_range(0, 3) != 0) ^ (cyc >= 400 && cyc < 500);
            room = DEPTH - ((w_cnt - m_rd + LAP) % LAP);
            if (room > 0 && $urandom_range(0, 2) != 0) begin
                tb_mem[w_cnt % DEPTH] = 8'($urandom);
                w_cnt = (w_cnt + 1) % LAP;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
